vga_frame_reader: RTL

Upstream feeder for the VGA driver: streams one frame of RGB565 pixels from SDRAM into the driver's data_req/data interface. Issues burst read requests to the SDRAM controller read port and buffers returned words in an internal FIFO. Serves each data_req with the next pixel one cycle later. Restarts at frame base address on every v_sync falling edge.

---
 rtl/vga_frame_reader_pkg.sv | 25 ++
 rtl/vga_frame_reader_sync_fifo.sv | 62 ++++++
 rtl/vga_frame_reader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vga_frame_reader_pkg.sv
// Shared definitions for the VGA frame reader: pixel layout, FSM encoding and
// default geometry for the 1024x768 mode (720 fetched lines).
package vga_frame_reader_pkg;

    // RGB565 field positions within a pixel word
    localparam int RGB_R_LSB = 11;
    localparam int RGB_R_W   = 5;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_G_W   = 6;
    localparam int RGB_B_LSB = 0;
    localparam int RGB_B_W   = 5;

    localparam int DEF_FRAME_WORDS = 737280;
    localparam int DEF_BURST_LEN   = 256;
    localparam int RD_LEN_W        = 9;
    localparam int WORDS_LEFT_W    = 20;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_FLUSH     = 2'd3
    } rd_state_t;

endpackage

// File: rtl/vga_frame_reader_sync_fifo.sv
// Single-clock pixel buffer with synchronous clear and registered read data.
// A pop loads the head word into pop_data; any other cycle returns zero.
module vga_frame_reader_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & ~clear & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pop_data <= '0;
        end else begin
            pop_data <= do_pop ? mem[rd_ptr] : '0;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                if (do_push && !do_pop) begin
                    level <= level + 1'b1;
                end else if (do_pop && !do_push) begin
                    level <= level - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Streams one frame of pixels from SDRAM into the VGA driver's request port.
// Bursts are only requested when the FIFO has room for the whole burst.
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 24,
    parameter int unsigned ADDR_BASE   = 0,
    parameter int          FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int          BURST_LEN   = DEF_BURST_LEN,
    parameter int          FIFO_DEPTH  = 512
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          v_sync,
    input  logic                          data_req,
    output logic [DATA_W-1:0]             data,
    output logic                          rd_req,
    output logic [ADDR_W-1:0]             rd_addr,
    output logic [8:0]                    rd_len,
    input  logic                          rd_ack,
    input  logic                          rd_valid,
    input  logic [DATA_W-1:0]             rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic [1:0]                    state_dbg
);

    // Handshake: rd_req rises with rd_addr/rd_len and all three hold until the
    // single-cycle rd_ack; rd_valid beats are only accepted after that ack.

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] SPACE_LIMIT = LVL_W'(FIFO_DEPTH - BURST_LEN);

    rd_state_t                 state;
    rd_state_t                 next_state;
    logic                      v_sync_d;
    logic                      frame_start;
    logic                      restart_pending;
    logic [ADDR_W-1:0]         addr;
    logic [WORDS_LEFT_W-1:0]   words_left;
    logic [RD_LEN_W-1:0]       beat_cnt;
    logic [RD_LEN_W-1:0]       next_len;
    logic                      start_burst;
    logic                      burst_done;
    logic                      flush;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_empty;
    logic                      fifo_full;

    assign frame_start = v_sync_d & ~v_sync;
    assign next_len    = (words_left < WORDS_LEFT_W'(BURST_LEN)) ?
                         words_left[RD_LEN_W-1:0] : RD_LEN_W'(BURST_LEN);
    assign state_dbg   = state;

    always_comb begin
        next_state  = state;
        start_burst = 1'b0;
        burst_done  = 1'b0;
        flush       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_start || restart_pending) begin
                    next_state = ST_FLUSH;
                end else if (words_left != '0 && fifo_level <= SPACE_LIMIT) begin
                    next_state  = ST_REQ;
                    start_burst = 1'b1;
                end
            end
            ST_REQ: begin
                if (rd_ack) next_state = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (rd_valid && (beat_cnt + 1'b1 == rd_len)) begin
                    burst_done = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush      = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Beats of a burst interrupted by a new frame are drained but not stored.
    assign fifo_push = (state == ST_WAIT_DATA) & rd_valid & ~restart_pending & ~fifo_full;
    assign fifo_pop  = data_req & ~flush;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            v_sync_d        <= 1'b1;
            restart_pending <= 1'b0;
            addr            <= ADDR_W'(ADDR_BASE);
            words_left      <= '0;
            beat_cnt        <= '0;
            rd_req          <= 1'b0;
            rd_addr         <= ADDR_W'(ADDR_BASE);
            rd_len          <= '0;
            underflow       <= 1'b0;
        end else begin
            state    <= next_state;
            v_sync_d <= v_sync;
            if (data_req && fifo_empty) underflow <= 1'b1;
            if (flush) begin
                addr            <= ADDR_W'(ADDR_BASE);
                words_left      <= WORDS_LEFT_W'(FRAME_WORDS);
                restart_pending <= 1'b0;
            end else if (frame_start && (state == ST_REQ || state == ST_WAIT_DATA)) begin
                restart_pending <= 1'b1;
            end
            if (start_burst) begin
                rd_req  <= 1'b1;
                rd_addr <= addr;
                rd_len  <= next_len;
            end
            if (state == ST_REQ && rd_ack) begin
                rd_req   <= 1'b0;
                beat_cnt <= '0;
            end
            if (state == ST_WAIT_DATA && rd_valid) beat_cnt <= beat_cnt + 1'b1;
            if (burst_done) begin
                addr       <= addr + ADDR_W'(rd_len);
                words_left <= words_left - WORDS_LEFT_W'(rd_len);
            end
        end
    end

    vga_frame_reader_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (rd_data),
        .pop       (fifo_pop),
        .pop_data  (data),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
